// File: rtl/shape_processor_cmd_feeder.sv
// Command feeder for the shape processor: buffers (shape, operation) commands, writes each to the
// CTRL SFR, reads it back and reports per-command accept/reject plus any error seen in flight.
//
// state | meaning
// IDLE  | nothing in flight, waiting for a queued command
// WRITE | CTRL SFR write strobe with the current command
// READ  | CTRL SFR read strobe
// CHECK | compare read-back fields against the command
// RESP  | response presented, waiting for rsp_ready_i
module shape_processor_cmd_feeder #(
   parameter int DEPTH     = 4,
   parameter int SHAPE_W   = 2,
   parameter int OP_W      = 2,
   parameter int SHAPE_LSB = 0,
   parameter int OP_LSB    = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [SHAPE_W-1:0] cmd_shape_i,
   input  logic [OP_W-1:0]    cmd_operation_i,
   output logic               write_o,
   output logic [31:0]        write_data_o,
   output logic               read_o,
   input  logic [31:0]        read_data_i,
   input  logic               error_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic               rsp_accepted_o,
   output logic               rsp_error_o,
   output logic               busy_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CMD_W = SHAPE_W + OP_W;
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_CHECK,
      ST_RESP
   } state_t;

   state_t             state_q, state_d;
   logic [CMD_W-1:0]   mem_q [DEPTH];
   logic [AW:0]        wr_ptr_q, rd_ptr_q;
   logic [CMD_W-1:0]   cmd_q, cmd_d;
   logic               acc_q, acc_d;
   logic               err_q, err_d;

   logic               full, empty, push, pop, launch;
   logic [CMD_W-1:0]   head;
   logic [SHAPE_W-1:0] cmd_shape;
   logic [OP_W-1:0]    cmd_op;
   logic               unused_rd;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push  = cmd_valid_i && !full;
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   assign cmd_shape = cmd_q[OP_W +: SHAPE_W];
   assign cmd_op    = cmd_q[0 +: OP_W];
   assign unused_rd = ^read_data_i;

   // FIFO storage and pointers; pop is owned by the FSM launch decision.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {cmd_shape_i, cmd_operation_i};
            wr_ptr_q                <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cmd_q   <= '0;
         acc_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         acc_q   <= acc_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      acc_d        = acc_q;
      err_d        = err_q;
      launch       = 1'b0;
      pop          = 1'b0;
      write_o      = 1'b0;
      read_o       = 1'b0;
      write_data_o = '0;

      case (state_q)
         ST_IDLE: begin
            launch = !empty;
         end
         ST_WRITE: begin
            write_o                            = 1'b1;
            write_data_o[SHAPE_LSB +: SHAPE_W] = cmd_shape;
            write_data_o[OP_LSB +: OP_W]       = cmd_op;
            err_d                              = err_q | error_i;
            state_d                            = ST_READ;
         end
         ST_READ: begin
            read_o  = 1'b1;
            err_d   = err_q | error_i;
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            acc_d   = (read_data_i[SHAPE_LSB +: SHAPE_W] == cmd_shape) &&
                      (read_data_i[OP_LSB +: OP_W] == cmd_op);
            err_d   = err_q | error_i;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               launch  = !empty;
               acc_d   = 1'b0;
               err_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A new command always starts with a clean response and error history.
      if (launch) begin
         pop     = 1'b1;
         cmd_d   = head;
         acc_d   = 1'b0;
         err_d   = 1'b0;
         state_d = ST_WRITE;
      end
   end

   assign cmd_ready_o    = !full;
   assign rsp_valid_o    = (state_q == ST_RESP);
   assign rsp_accepted_o = acc_q;
   assign rsp_error_o    = err_q;
   assign busy_o         = (state_q != ST_IDLE) || !empty;

endmodule

// File: tb/tb_shape_processor_cmd_feeder.sv
// Bench for shape_processor_cmd_feeder: directed commands against a small CTRL SFR model, with a
// response scoreboard checked by an independent monitor.
module tb_shape_processor_cmd_feeder;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_shape, cmd_operation;
   logic        write, read;
   logic [31:0] write_data, read_data;
   logic        error;
   logic        rsp_valid, rsp_ready, rsp_accepted, rsp_error, busy;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [1:0]  exp_q[$];
   logic [31:0] sfr;

   always #5 clk = ~clk;

   shape_processor_cmd_feeder #(
      .DEPTH(DEPTH), .SHAPE_W(2), .OP_W(2), .SHAPE_LSB(0), .OP_LSB(8)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_shape_i(cmd_shape), .cmd_operation_i(cmd_operation),
      .write_o(write), .write_data_o(write_data),
      .read_o(read), .read_data_i(read_data), .error_i(error),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_accepted_o(rsp_accepted), .rsp_error_o(rsp_error), .busy_o(busy)
   );

   // CTRL SFR model: OPERATION==3 is illegal and leaves the register unchanged.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sfr       <= 32'h0;
         read_data <= 32'h0;
      end else begin
         if (write && write_data[9:8] != 2'd3) sfr <= write_data;
         if (read) read_data <= sfr;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: pops on each handshake, and checks rsp_* hold while stalled.
   logic       hold_v = 1'b0;
   logic [1:0] hold_val;
   always @(negedge clk) begin
      if (rst) begin
         hold_v = 1'b0;
      end else if (rsp_valid) begin
         if (hold_v) begin
            check("rsp_accepted_stable", rsp_accepted, hold_val[1]);
            check("rsp_error_stable", rsp_error, hold_val[0]);
         end
         if (rsp_ready) begin
            hold_v = 1'b0;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rsp_unexpected: got rsp_valid with empty scoreboard at %0t", $time);
            end else begin
               logic [1:0] e;
               e = exp_q.pop_front();
               check("rsp_accepted", rsp_accepted, e[1]);
               check("rsp_error", rsp_error, e[0]);
            end
         end else begin
            hold_v   = 1'b1;
            hold_val = {rsp_accepted, rsp_error};
         end
      end else begin
         hold_v = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] shape, input logic [1:0] op,
                       input logic exp_acc, input logic exp_err);
      bit done = 1'b0;
      cmd_valid     = 1'b1;
      cmd_shape     = shape;
      cmd_operation = op;
      for (int i = 0; i < 200 && !done; i++) begin
         if (cmd_ready) begin
            @(posedge clk);
            exp_q.push_back({exp_acc, exp_err});
            done = 1'b1;
            #1;
         end else begin
            tick();
         end
      end
      cmd_valid = 1'b0;
      check("push_accepted", done, 1);
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         if (!busy && exp_q.size() == 0) done = 1'b1;
         else tick();
      end
      check("idle_timeout", done, 1);
   endtask

   initial begin
      bit saw_write, saw_rv, stall_ready;

      rst           = 1'b1;
      cmd_valid     = 1'b0;
      cmd_shape     = 2'd0;
      cmd_operation = 2'd0;
      error         = 1'b0;
      rsp_ready     = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (5) tick();
      check("reset_cmd_ready", cmd_ready, 1);
      check("reset_write", write, 0);
      check("reset_read", read, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_write_data", write_data, 32'h0);

      // Latency of a single legal command.
      push(2'd1, 2'd2, 1'b1, 1'b0);
      tick();
      check("lat_write", write, 1);
      check("lat_write_data", write_data, 32'h0000_0201);
      check("lat_write_read_low", read, 0);
      check("lat_busy", busy, 1);
      tick();
      check("lat_read", read, 1);
      check("lat_read_write_low", write, 0);
      tick();
      check("lat_rsp_not_yet", rsp_valid, 0);
      tick();
      check("lat_rsp_valid", rsp_valid, 1);
      wait_idle();

      // Illegal command reads back the previous legal value.
      push(2'd2, 2'd1, 1'b1, 1'b0);
      push(2'd1, 2'd3, 1'b0, 1'b0);
      push(2'd3, 2'd0, 1'b1, 1'b0);
      wait_idle();

      // Backpressure: DEPTH+1 commands, responses stalled.
      rsp_ready = 1'b0;
      push(2'd0, 2'd0, 1'b1, 1'b0);
      push(2'd1, 2'd3, 1'b0, 1'b0);
      push(2'd2, 2'd2, 1'b1, 1'b0);
      push(2'd0, 2'd3, 1'b0, 1'b0);
      push(2'd1, 2'd0, 1'b1, 1'b0);
      check("full_cmd_ready", cmd_ready, 0);
      stall_ready = 1'b0;
      repeat (6) begin
         tick();
         stall_ready = stall_ready | cmd_ready;
      end
      check("full_cmd_ready_held", stall_ready, 0);
      check("full_rsp_valid", rsp_valid, 1);
      rsp_ready = 1'b1;
      wait_idle();

      // Error pulse during READ of the first command only.
      push(2'd2, 2'd1, 1'b1, 1'b1);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            if (read) seen = 1'b1;
            else tick();
         end
         check("err_read_seen", seen, 1);
         error = 1'b1;
         tick();
         error = 1'b0;
      end
      wait_idle();
      push(2'd0, 2'd2, 1'b1, 1'b0);
      wait_idle();

      // Reset during READ with two commands queued.
      push(2'd1, 2'd1, 1'b1, 1'b0);
      push(2'd2, 2'd2, 1'b1, 1'b0);
      push(2'd3, 2'd3, 1'b0, 1'b0);
      check("rst_in_read", read, 1);
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_write", write, 0);
      check("rst_read", read, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_accepted", rsp_accepted, 0);
      check("rst_rsp_error", rsp_error, 0);
      check("rst_busy", busy, 0);
      check("rst_write_data", write_data, 32'h0);
      tick();
      rst = 1'b0;
      saw_write = 1'b0;
      saw_rv    = 1'b0;
      repeat (12) begin
         tick();
         saw_write = saw_write | write;
         saw_rv    = saw_rv | rsp_valid;
      end
      check("post_rst_no_write", saw_write, 0);
      check("post_rst_no_rsp", saw_rv, 0);
      check("post_rst_busy", busy, 0);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
